mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Multicycle CPU control unit; successor to the combinational instruction decoder.
- Decodes the IR contents, sequences FETCH/DECODE/EXEC/MEM/WB per instruction, and drives all datapath enables and muxes.
- Handles variable memory latency through a ready handshake with timeout, traps illegal opcodes, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory access may wait for mem_ready before trapping (>=1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  IR output; stable from the cycle after ir_we
- zero  in  1  ALU zero flag; valid in EXEC
- mem_ready  in  1  memory completes current access this cycle
- mem_re  out  1  memory read request (FETCH, lw MEM)
- mem_we  out  1  memory write request (sw MEM)
- ir_we  out  1  load IR
- pc_we  out  1  load PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- reg_we  out  1  register-file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALU result, 1 = MDR
- alu_op  out  3  0 add, 1 sub, 2 or, 3 sll, 4 slt
- alu_src_b  out  2  0 rt, 1 const 4, 2 sign-ext imm, 3 zero-ext imm
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7
- trap  out  1  high while in TRAP
- trap_cause  out  1  0 = illegal instruction, 1 = memory timeout
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH.
  - All enables and muxes 0.
  - trap=0, trap_cause=0, retired=0, wait counter 0.
- Outputs are decoded from the registered state plus a class register latched in DECODE. No output is combinational from inst except in DECODE.
- Supported instructions:
  - R-type (op 0): addu (funct 0x21), subu (0x23), sll (0x00).
  - I-type: ori (0x0D), lw (0x23), sw (0x2B), beq (0x04).
  - J-type: j (0x02).
  - Any other op/funct is illegal.
- FETCH:
  - mem_re=1 and alu_src_b=1 for as long as the state persists.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0 in that same cycle, then go to DECODE.
- DECODE:
  - Latch the class.
  - Illegal instruction: go to TRAP, trap_cause=0.
  - j: pc_we=1, pc_src=2, retire, go to FETCH.
  - All others: go to EXEC.
- EXEC:
  - addu: alu_op=0, alu_src_b=0.
  - subu: alu_op=1, alu_src_b=0.
  - sll: alu_op=3, alu_src_b=0.
  - ori: alu_op=2, alu_src_b=3.
  - lw/sw: alu_op=0, alu_src_b=2, then go to MEM.
  - beq: alu_op=1, alu_src_b=0, pc_we=zero, pc_src=1, retire, go to FETCH.
  - ALU-class instructions go to WB.
- MEM:
  - lw: mem_re=1; on mem_ready go to WB.
  - sw: mem_we=1; on mem_ready retire and go to FETCH.
- WB:
  - reg_we=1, retire, go to FETCH.
  - R-type: reg_dst=1. ori/lw: reg_dst=0.
  - lw: mem_to_reg=1.
- Latency with mem_ready tied high:
  - j: 2 cycles.
  - beq: 3 cycles.
  - R-type, ori, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Memory wait counter:
  - Clears on entry to FETCH or MEM; increments each cycle mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP, trap_cause=1.
  - mem_ready in the same cycle the count reaches MEM_TIMEOUT completes normally; ready wins.
- TRAP:
  - All enables 0, trap=1.
  - Stays in TRAP until reset.
- retired:
  - Increments by 1 in the retire cycle; wraps modulo 2^CNT_W.
  - Never increments in TRAP or for an illegal instruction.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-instruction: immediate return to FETCH with all enables 0. No partial write completes after rst_n falls.

Optional Feature:
- MC_CTRL_EXT_INST_EN defined: addiu (op 0x09; alu_op=0, alu_src_b=2, WB to rt) and slt (R-type funct 0x2A; alu_op=4, WB to rd) are legal. Both take 4 cycles.
- Undefined: op 0x09 and funct 0x2A are illegal and trap with trap_cause=0.

Test Plan:
- inst=0x00221821 (addu $3,$1,$2), mem_ready=1 -> states 0,1,2,4; reg_we=1 and reg_dst=1 only in WB; retired 0->1.
- inst=0x8C220004 (lw), mem_ready low 3 cycles in MEM -> MEM lasts 4 cycles; then WB with mem_to_reg=1, reg_dst=0; total 8 cycles.
- inst=0x10220002 (beq): zero=1 -> pc_we=1, pc_src=1 in EXEC; zero=0 -> pc_we=0; 3 cycles either way.
- inst=0x08000010 (j) -> DECODE has pc_we=1, pc_src=2; back in FETCH after 2 cycles; retired+1.
- inst=0xFC000000 -> TRAP after DECODE, trap_cause=0; retired unchanged; rst_n pulse returns to FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 cycles, trap_cause=1. Repeat with mem_ready=1 on the 4th cycle -> normal DECODE.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Signal bundle between the multicycle control unit and its datapath/memory.
// Drive side of the control unit is the master modport; the datapath/memory side is the slave.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      inst;
    logic             zero;
    // Memory handshake: mem_re/mem_we is a request held for every cycle of an access;
    // the access completes in the first cycle that also sees mem_ready=1, and mem_ready
    // in any cycle without a request has no effect.
    logic             mem_ready;
    logic             mem_re;
    logic             mem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             reg_we;
    logic             reg_dst;
    logic             mem_to_reg;
    logic [2:0]       alu_op;
    logic [1:0]       alu_src_b;
    logic [2:0]       state;
    logic             trap;
    logic             trap_cause;
    logic [CNT_W-1:0] retired;

    modport master (
        input  inst, zero, mem_ready,
        output mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
               alu_op, alu_src_b, state, trap, trap_cause, retired
    );

    modport slave (
        output inst, zero, mem_ready,
        input  mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
               alu_op, alu_src_b, state, trap, trap_cause, retired
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, memory timeout and illegal-op traps.
// Define MC_CTRL_EXT_INST_EN to make addiu and slt legal instructions.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);
`ifdef MC_CTRL_EXT_INST_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    // The wait counter only needs to hold up to MEM_TIMEOUT-1; reaching that value with no ready traps.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_ADDU, C_SUBU, C_SLL, C_SLT, C_ORI, C_ADDIU, C_LW, C_SW, C_BEQ, C_J
    } class_t;

    state_t            r_state, w_next;
    class_t            r_class, w_class;
    logic [WAIT_W-1:0] r_wait, w_wait_next;
    logic [CNT_W-1:0]  r_retired;
    logic              r_cause;

    logic [5:0] w_op, w_funct;
    logic       w_timeout, w_retire, w_to_trap, w_cause;
    logic       w_mem_re, w_mem_we, w_ir_we, w_pc_we, w_reg_we, w_reg_dst, w_mem_to_reg, w_trap;
    logic [1:0] w_pc_src, w_alu_src_b;
    logic [2:0] w_alu_op;

    assign w_op    = bus.inst[31:26];
    assign w_funct = bus.inst[5:0];

    always_comb begin
        w_class = C_ILL;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h21:   w_class = C_ADDU;
                    6'h23:   w_class = C_SUBU;
                    6'h00:   w_class = C_SLL;
                    6'h2A:   w_class = EXT_EN ? C_SLT : C_ILL;
                    default: w_class = C_ILL;
                endcase
            end
            6'h0D:   w_class = C_ORI;
            6'h09:   w_class = EXT_EN ? C_ADDIU : C_ILL;
            6'h23:   w_class = C_LW;
            6'h2B:   w_class = C_SW;
            6'h04:   w_class = C_BEQ;
            6'h02:   w_class = C_J;
            default: w_class = C_ILL;
        endcase
    end

    assign w_timeout = !bus.mem_ready && (r_wait == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_class   <= C_ILL;
            r_wait    <= '0;
            r_retired <= '0;
            r_cause   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (r_state == S_DECODE) r_class <= w_class;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
            if (w_to_trap) r_cause <= w_cause;
        end
    end

    // Outputs are forced low while rst_n is asserted so no request leaks out during reset.
    always_comb begin
        w_next       = r_state;
        w_wait_next  = '0;
        w_retire     = 1'b0;
        w_to_trap    = 1'b0;
        w_cause      = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = 2'd0;
        w_reg_we     = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_op     = 3'd0;
        w_alu_src_b  = 2'd0;
        w_trap       = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_re    = 1'b1;
                    w_alu_src_b = 2'd1;
                    if (bus.mem_ready) begin
                        w_ir_we = 1'b1;
                        w_pc_we = 1'b1;
                        w_next  = S_DECODE;
                    end else if (w_timeout) begin
                        w_next    = S_TRAP;
                        w_to_trap = 1'b1;
                        w_cause   = 1'b1;
                    end else begin
                        w_wait_next = r_wait + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    case (w_class)
                        C_ILL: begin
                            w_next    = S_TRAP;
                            w_to_trap = 1'b1;
                        end
                        C_J: begin
                            w_pc_we  = 1'b1;
                            w_pc_src = 2'd2;
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end
                        default: w_next = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    w_next = S_WB;
                    case (r_class)
                        C_ADDU:  w_alu_op = 3'd0;
                        C_SUBU:  w_alu_op = 3'd1;
                        C_SLL:   w_alu_op = 3'd3;
                        C_SLT:   w_alu_op = 3'd4;
                        C_ORI: begin
                            w_alu_op    = 3'd2;
                            w_alu_src_b = 2'd3;
                        end
                        C_ADDIU: w_alu_src_b = 2'd2;
                        C_LW, C_SW: begin
                            w_alu_src_b = 2'd2;
                            w_next      = S_MEM;
                        end
                        C_BEQ: begin
                            w_alu_op = 3'd1;
                            w_pc_we  = bus.zero;
                            w_pc_src = 2'd1;
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end
                        default: begin
                            w_next    = S_TRAP;
                            w_to_trap = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    w_mem_we = (r_class == C_SW);
                    w_mem_re = (r_class != C_SW);
                    if (bus.mem_ready) begin
                        w_retire = (r_class == C_SW);
                        w_next   = (r_class == C_SW) ? S_FETCH : S_WB;
                    end else if (w_timeout) begin
                        w_next    = S_TRAP;
                        w_to_trap = 1'b1;
                        w_cause   = 1'b1;
                    end else begin
                        w_wait_next = r_wait + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    w_reg_we     = 1'b1;
                    w_reg_dst    = (r_class == C_ADDU) || (r_class == C_SUBU) ||
                                   (r_class == C_SLL)  || (r_class == C_SLT);
                    w_mem_to_reg = (r_class == C_LW);
                    w_retire     = 1'b1;
                    w_next       = S_FETCH;
                end
                S_TRAP:  w_trap = 1'b1;
                default: begin
                    w_next    = S_TRAP;
                    w_to_trap = 1'b1;
                end
            endcase
        end
    end

    assign bus.mem_re     = w_mem_re;
    assign bus.mem_we     = w_mem_we;
    assign bus.ir_we      = w_ir_we;
    assign bus.pc_we      = w_pc_we;
    assign bus.pc_src     = w_pc_src;
    assign bus.reg_we     = w_reg_we;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_op     = w_alu_op;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.state      = r_state;
    assign bus.trap       = w_trap;
    assign bus.trap_cause = r_cause;
    assign bus.retired    = r_retired;
endmodule
